// File: rtl/hazard_ctrl_if.sv
// Bundle between the five-stage pipeline and its hazard controller.
// The master side is the pipeline datapath; the slave side is hazard_ctrl.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_jump;
  logic             id_halt;
  logic [4:0]       ex_rd;
  logic [4:0]       mem_rd;
  logic [4:0]       wb_rd;
  logic             ex_regwrite;
  logic             mem_regwrite;
  logic             wb_regwrite;
  logic             ex_memread;
  logic             ex_branch_taken;
  logic             go;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_clear;
  logic             idex_clear;
  logic [1:0]       fwd_rs_sel;
  logic [1:0]       fwd_rt_sel;
  logic             halted;
  logic [CNT_W-1:0] load_use_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_halt,
           ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite,
           ex_memread, ex_branch_taken, go,
    input  pc_stall, ifid_stall, ifid_clear, idex_clear,
           fwd_rs_sel, fwd_rt_sel, halted, load_use_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_jump, id_halt,
           ex_rd, mem_rd, wb_rd, ex_regwrite, mem_regwrite, wb_regwrite,
           ex_memread, ex_branch_taken, go,
    output pc_stall, ifid_stall, ifid_clear, idex_clear,
           fwd_rs_sel, fwd_rt_sel, halted, load_use_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the five-stage redirect pipeline,
// with a halt drain sequence and load-use / branch-flush event counters.
//
//   state     | meaning
//   ST_RUN    | normal operation
//   ST_DRAIN  | halt accepted, pipeline drains for three cycles
//   ST_HALTED | pipeline stopped until a go pulse
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t           r_state;
  logic [1:0]       r_drain_cnt;
  logic             r_halted;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_lu;
  logic       w_pc_stall, w_ifid_stall, w_ifid_clear, w_idex_clear;
  logic       w_take_flush, w_take_halt, w_take_lu;
  logic [1:0] w_fwd_rs, w_fwd_rt;

  // A load in EX never forwards; the select falls through to MEM/WB.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src, input logic [4:0] ex_rd, input logic ex_ok,
    input logic [4:0] mem_rd, input logic mem_ok,
    input logic [4:0] wb_rd, input logic wb_ok);
    if (src == 5'd0)                   return 2'd0;
    else if (ex_ok && ex_rd == src)    return 2'd1;
    else if (mem_ok && mem_rd == src)  return 2'd2;
    else if (wb_ok && wb_rd == src)    return 2'd3;
    else                               return 2'd0;
  endfunction

  assign w_lu = bus.ex_memread && bus.ex_regwrite && (bus.ex_rd != 5'd0) &&
                ((bus.id_use_rs && bus.ex_rd == bus.id_rs) ||
                 (bus.id_use_rt && bus.ex_rd == bus.id_rt));

  always_comb begin
    w_pc_stall   = 1'b0;
    w_ifid_stall = 1'b0;
    w_ifid_clear = 1'b0;
    w_idex_clear = 1'b0;
    w_take_flush = 1'b0;
    w_take_halt  = 1'b0;
    w_take_lu    = 1'b0;
    w_fwd_rs = fwd_sel(bus.id_rs, bus.ex_rd, bus.ex_regwrite && !bus.ex_memread,
                       bus.mem_rd, bus.mem_regwrite, bus.wb_rd, bus.wb_regwrite);
    w_fwd_rt = fwd_sel(bus.id_rt, bus.ex_rd, bus.ex_regwrite && !bus.ex_memread,
                       bus.mem_rd, bus.mem_regwrite, bus.wb_rd, bus.wb_regwrite);
    if (rst) begin
      w_ifid_clear = 1'b1;
      w_idex_clear = 1'b1;
      w_fwd_rs     = 2'd0;
      w_fwd_rt     = 2'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.ex_branch_taken) begin
            w_ifid_clear = 1'b1;
            w_idex_clear = 1'b1;
            w_take_flush = 1'b1;
          end else if (bus.id_halt && !w_lu) begin
            {w_pc_stall, w_ifid_stall, w_idex_clear} = 3'b111;
            w_take_halt = 1'b1;
          end else if (w_lu) begin
            {w_pc_stall, w_ifid_stall, w_idex_clear} = 3'b111;
            w_take_lu = 1'b1;
          end else if (bus.id_jump) begin
            w_ifid_clear = 1'b1;
          end
        end
        ST_HALTED: begin
          if (bus.go) begin
            w_ifid_clear = 1'b1;
            w_idex_clear = 1'b1;
          end else begin
            {w_pc_stall, w_ifid_stall, w_idex_clear} = 3'b111;
          end
        end
        default: {w_pc_stall, w_ifid_stall, w_idex_clear} = 3'b111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= 2'd0;
      r_halted    <= 1'b0;
      r_lu_cnt    <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_take_flush) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
          if (w_take_lu)    r_lu_cnt    <= r_lu_cnt + CNT_W'(1);
          if (w_take_halt) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= 2'd0;
          end
        end
        ST_DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 2'd1;
          if (r_drain_cnt == 2'd2) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (bus.go) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc_stall     = w_pc_stall;
  assign bus.ifid_stall   = w_ifid_stall;
  assign bus.ifid_clear   = w_ifid_clear;
  assign bus.idex_clear   = w_idex_clear;
  assign bus.fwd_rs_sel   = w_fwd_rs;
  assign bus.fwd_rt_sel   = w_fwd_rt;
  assign bus.halted       = r_halted;
  assign bus.load_use_cnt = r_lu_cnt;
  assign bus.flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus randomized traffic checked against a rule-level
// model of the hazard controller (halt countdown, counters, priority rules).
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  hazard_ctrl_if #(.CNT_W(32)) bus();
  hazard_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_halted     = 1'b0;
  int          m_drain_left = 0;
  logic [31:0] m_lu = '0;
  logic [31:0] m_fl = '0;
  // model expectations for the current cycle
  logic       e_pc, e_ifs, e_ifc, e_idc;
  logic [1:0] e_frs, e_frt;
  bit         e_lu_take, e_fl_take, e_halt_take, e_go_take;

  function automatic logic [1:0] ref_fwd(input logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    if (bus.ex_regwrite && !bus.ex_memread && bus.ex_rd == r) return 2'd1;
    if (bus.mem_regwrite && bus.mem_rd == r) return 2'd2;
    if (bus.wb_regwrite && bus.wb_rd == r) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_outputs();
    bit lu;
    lu = bus.ex_memread && bus.ex_regwrite && bus.ex_rd != 5'd0 &&
         ((bus.id_use_rs && bus.ex_rd == bus.id_rs) || (bus.id_use_rt && bus.ex_rd == bus.id_rt));
    {e_pc, e_ifs, e_ifc, e_idc} = 4'b0000;
    {e_lu_take, e_fl_take, e_halt_take, e_go_take} = 4'b0000;
    e_frs = ref_fwd(bus.id_rs);
    e_frt = ref_fwd(bus.id_rt);
    if (rst) begin
      e_ifc = 1; e_idc = 1; e_frs = 0; e_frt = 0;
    end else if (m_drain_left > 0) begin
      e_pc = 1; e_ifs = 1; e_idc = 1;
    end else if (m_halted) begin
      if (bus.go) begin e_ifc = 1; e_idc = 1; e_go_take = 1; end
      else begin e_pc = 1; e_ifs = 1; e_idc = 1; end
    end else if (bus.ex_branch_taken) begin
      e_ifc = 1; e_idc = 1; e_fl_take = 1;
    end else if (bus.id_halt && !lu) begin
      e_pc = 1; e_ifs = 1; e_idc = 1; e_halt_take = 1;
    end else if (lu) begin
      e_pc = 1; e_ifs = 1; e_idc = 1; e_lu_take = 1;
    end else if (bus.id_jump) begin
      e_ifc = 1;
    end
  endtask

  task automatic model_advance();
    if (rst) begin
      m_halted = 0; m_drain_left = 0; m_lu = '0; m_fl = '0;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) m_halted = 1;
    end else if (m_halted) begin
      if (e_go_take) m_halted = 0;
    end else begin
      if (e_fl_take) m_fl++;
      if (e_lu_take) m_lu++;
      if (e_halt_take) m_drain_left = 3;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_outputs();
  endtask

  task automatic step();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle();
    bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_jump = 0; bus.id_halt = 0; bus.ex_rd = 0; bus.mem_rd = 0; bus.wb_rd = 0;
    bus.ex_regwrite = 0; bus.mem_regwrite = 0; bus.wb_regwrite = 0;
    bus.ex_memread = 0; bus.ex_branch_taken = 0; bus.go = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    bus.id_rs = 3; bus.ex_rd = 3; bus.ex_regwrite = 1; bus.id_use_rs = 1;
    settle();
    total++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.fwd_rs_sel} !== 6'b0011_00) begin
      bad++; $display("FAIL reset_forced got=%b exp=001100",
        {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.fwd_rs_sel});
    end
    step();
    total++;
    if ({bus.halted, bus.load_use_cnt, bus.flush_cnt} !== 65'd0) begin
      bad++; $display("FAIL reset_regs halted=%b lu=%0d fl=%0d exp all 0", bus.halted, bus.load_use_cnt, bus.flush_cnt);
    end
    rst = 0; idle();
  endtask

  task automatic test_load_use();
    logic [31:0] lu0;
    idle();
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_rd = 8; bus.id_rs = 8; bus.id_use_rs = 1;
    settle();
    lu0 = m_lu;
    total++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear} !== 4'b1101) begin
      bad++; $display("FAIL load_use_ctrl got=%b exp=1101", {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear});
    end
    step();
    total++;
    if (bus.load_use_cnt !== lu0 + 1) begin
      bad++; $display("FAIL load_use_cnt got=%0d exp=%0d", bus.load_use_cnt, lu0 + 1);
    end
    bus.ex_memread = 0;
    settle();
    total++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.fwd_rs_sel} !== 6'b0000_01) begin
      bad++; $display("FAIL load_use_after got=%b exp=000001",
        {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.fwd_rs_sel});
    end
    step();
  endtask

  task automatic test_zero_reg();
    idle();
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_rd = 0; bus.id_rs = 0; bus.id_use_rs = 1;
    settle();
    total++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.fwd_rs_sel} !== 6'b0000_00) begin
      bad++; $display("FAIL zero_reg got=%b exp=000000",
        {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.fwd_rs_sel});
    end
    step();
  endtask

  task automatic test_branch_wins();
    logic [31:0] lu0, fl0;
    idle();
    bus.ex_branch_taken = 1; bus.id_halt = 1; bus.id_jump = 1;
    bus.ex_memread = 1; bus.ex_regwrite = 1; bus.ex_rd = 5; bus.id_rt = 5; bus.id_use_rt = 1;
    settle();
    lu0 = m_lu; fl0 = m_fl;
    total++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear} !== 4'b0011) begin
      bad++; $display("FAIL branch_ctrl got=%b exp=0011", {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear});
    end
    step();
    total++;
    if (bus.flush_cnt !== fl0 + 1 || bus.load_use_cnt !== lu0) begin
      bad++; $display("FAIL branch_cnt fl=%0d lu=%0d exp fl=%0d lu=%0d", bus.flush_cnt, bus.load_use_cnt, fl0 + 1, lu0);
    end
    idle();
    settle();
    total++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.halted} !== 5'b00000) begin
      bad++; $display("FAIL branch_stays_run got=%b exp=00000",
        {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.halted});
    end
    step();
  endtask

  task automatic test_halt_resume();
    idle();
    bus.id_halt = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      total++;
      if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.halted} !== 5'b11010) begin
        bad++; $display("FAIL halt_drain c=%0d got=%b exp=11010", c,
          {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.halted});
      end
      step();
      bus.id_halt = 0;
    end
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.halted} !== 5'b11011) begin
        bad++; $display("FAIL halt_hold c=%0d got=%b exp=11011", c,
          {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.halted});
      end
      step();
    end
    bus.go = 1;
    settle();
    total++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.halted} !== 5'b00111) begin
      bad++; $display("FAIL resume_go got=%b exp=00111",
        {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.halted});
    end
    step();
    bus.go = 0;
    settle();
    total++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.halted} !== 5'b00000) begin
      bad++; $display("FAIL resume_run got=%b exp=00000",
        {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.halted});
    end
    step();
  endtask

  task automatic test_fwd_priority();
    logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    idle();
    bus.id_rt = 3; bus.ex_rd = 3; bus.mem_rd = 3; bus.wb_rd = 3;
    for (int k = 0; k < 4; k++) begin
      bus.ex_regwrite  = (k == 0 || k == 3);
      bus.mem_regwrite = (k != 2);
      bus.wb_regwrite  = 1;
      bus.ex_memread   = (k == 3);
      settle();
      total++;
      if (bus.fwd_rt_sel !== exp_sel[k]) begin
        bad++; $display("FAIL fwd_priority k=%0d got=%0d exp=%0d", k, bus.fwd_rt_sel, exp_sel[k]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_drain();
    idle();
    bus.id_halt = 1;
    settle(); step();
    bus.id_halt = 0;
    settle(); step();
    rst = 1;
    settle();
    total++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear} !== 4'b0011) begin
      bad++; $display("FAIL rst_drain_forced got=%b exp=0011", {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear});
    end
    step();
    rst = 0;
    total++;
    if ({bus.halted, bus.load_use_cnt, bus.flush_cnt} !== 65'd0) begin
      bad++; $display("FAIL rst_drain_regs halted=%b lu=%0d fl=%0d exp all 0", bus.halted, bus.load_use_cnt, bus.flush_cnt);
    end
    settle();
    total++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear} !== 4'b0000) begin
      bad++; $display("FAIL rst_drain_residual got=%b exp=0000", {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear});
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.id_rs = 5'($urandom_range(0, 3));  bus.id_rt = 5'($urandom_range(0, 3));
      bus.ex_rd = 5'($urandom_range(0, 3));  bus.mem_rd = 5'($urandom_range(0, 3));
      bus.wb_rd = 5'($urandom_range(0, 3));
      bus.id_use_rs = 1'($urandom);  bus.id_use_rt = 1'($urandom);
      bus.ex_regwrite = 1'($urandom); bus.mem_regwrite = 1'($urandom);
      bus.wb_regwrite = 1'($urandom); bus.ex_memread = 1'($urandom);
      bus.id_jump = ($urandom_range(0, 3) == 0);
      bus.id_halt = ($urandom_range(0, 11) == 0);
      bus.ex_branch_taken = ($urandom_range(0, 5) == 0);
      bus.go = ($urandom_range(0, 3) == 0);
      settle();
      total++;
      if ({bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.fwd_rs_sel, bus.fwd_rt_sel} !==
          {e_pc, e_ifs, e_ifc, e_idc, e_frs, e_frt}) begin
        bad++; $display("FAIL rand_ctrl c=%0d got=%b exp=%b", c,
          {bus.pc_stall, bus.ifid_stall, bus.ifid_clear, bus.idex_clear, bus.fwd_rs_sel, bus.fwd_rt_sel},
          {e_pc, e_ifs, e_ifc, e_idc, e_frs, e_frt});
      end
      step();
      total++;
      if (bus.halted !== m_halted || bus.load_use_cnt !== m_lu || bus.flush_cnt !== m_fl) begin
        bad++; $display("FAIL rand_regs c=%0d halted=%b lu=%0d fl=%0d exp halted=%b lu=%0d fl=%0d", c,
          bus.halted, bus.load_use_cnt, bus.flush_cnt, m_halted, m_lu, m_fl);
      end
    end
    rst = 0; idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_wins();
    test_halt_resume();
    test_fwd_priority();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
